// File: rtl/washer_pkg.sv
// Shared encodings and default timing for the washer front-panel controller.
package washer_pkg;

  localparam logic [2:0] ST_READY     = 3'd0;
  localparam logic [2:0] ST_START_REQ = 3'd1;
  localparam logic [2:0] ST_RUNNING   = 3'd2;
  localparam logic [2:0] ST_PAUSED    = 3'd3;
  localparam logic [2:0] ST_FAULT     = 3'd4;
  localparam logic [2:0] ST_COMPLETE  = 3'd5;

  typedef enum logic [2:0] {
    S_READY     = ST_READY,
    S_START_REQ = ST_START_REQ,
    S_RUNNING   = ST_RUNNING,
    S_PAUSED    = ST_PAUSED,
    S_FAULT     = ST_FAULT,
    S_COMPLETE  = ST_COMPLETE
  } panel_state_t;

  localparam logic [1:0] PROG_NORMAL = 2'd0;
  localparam logic [1:0] PROG_DOUBLE = 2'd1;
  localparam logic [1:0] PROG_STEAM  = 2'd2;

  localparam int DEF_DEBOUNCE_CYCLES = 16;
  localparam int DEF_START_ACK_MAX   = 8;
  localparam int DEF_BUZZ_CYCLES     = 1000;
  localparam int DEF_CNT_W           = 16;

  function automatic logic [1:0] next_prog(input logic [1:0] p);
    return (p == PROG_STEAM) ? PROG_NORMAL : p + 2'd1;
  endfunction

endpackage

// File: rtl/panel_debouncer.sv
// Two-flop synchronizer plus stability down-counter; level flips after
// DEBOUNCE_CYCLES consecutive differing samples, with a pulse on rising flips.
module panel_debouncer #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise_pulse
);

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1, sync2;
  logic [CNT_W-1:0] stab_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1      <= 1'b0;
      sync2      <= 1'b0;
      level      <= 1'b0;
      rise_pulse <= 1'b0;
      stab_cnt   <= RELOAD;
    end else begin
      sync1      <= raw;
      sync2      <= sync1;
      rise_pulse <= 1'b0;
      if (sync2 == level) begin
        stab_cnt <= RELOAD;
      end else if (stab_cnt == '0) begin
        level      <= sync2;
        rise_pulse <= sync2;
        stab_cnt   <= RELOAD;
      end else begin
        stab_cnt <= stab_cnt - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/washer_panel_ctrl.sv
// Washer front-panel controller: debounced inputs, program select, start
// handshake, pause toggle, fault and completion tracking.
//
//   state     | meaning
//   READY     | idle, program select allowed, waiting for start press
//   START_REQ | start held high, waiting for sequencer to leave idle
//   RUNNING   | cycle in progress, door locked
//   PAUSED    | sequencer timers frozen, door locked
//   FAULT     | error or no start ack; waits for closed door
//   COMPLETE  | buzzer on for BUZZ_CYCLES, then READY
module washer_panel_ctrl
  import washer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int START_ACK_MAX   = DEF_START_ACK_MAX,
  parameter int BUZZ_CYCLES     = DEF_BUZZ_CYCLES,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_start_raw,
  input  logic       btn_pause_raw,
  input  logic       btn_mode_raw,
  input  logic       door_sensor_raw,
  input  logic       done,
  input  logic       error_signal,
  output logic       start,
  output logic       double_wash,
  output logic       dry_wash,
  output logic       time_pause,
  output logic       door_closed,
  output logic       door_lock,
  output logic [1:0] program_sel,
  output logic       led_running,
  output logic       led_paused,
  output logic       led_fault,
  output logic       buzzer
);

  logic start_lvl, pause_lvl, mode_lvl, door_lvl;
  logic start_press, pause_press, mode_press, door_rise;
  logic unused_db;

  panel_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_start (
    .clk(clk), .rst(rst), .raw(btn_start_raw), .level(start_lvl), .rise_pulse(start_press));
  panel_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_pause (
    .clk(clk), .rst(rst), .raw(btn_pause_raw), .level(pause_lvl), .rise_pulse(pause_press));
  panel_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_mode (
    .clk(clk), .rst(rst), .raw(btn_mode_raw), .level(mode_lvl), .rise_pulse(mode_press));
  panel_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_door (
    .clk(clk), .rst(rst), .raw(door_sensor_raw), .level(door_lvl), .rise_pulse(door_rise));

  // Button levels and the door rising edge are not consumed by the FSM.
  assign unused_db = ^{start_lvl, pause_lvl, mode_lvl, door_rise};

  panel_state_t     state, state_nxt;
  logic [CNT_W-1:0] tmr;
  logic [1:0]       prog;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_READY;
      tmr   <= '0;
      prog  <= PROG_NORMAL;
    end else begin
      state <= state_nxt;
      if (state_nxt == S_START_REQ && state != S_START_REQ)
        tmr <= CNT_W'(START_ACK_MAX - 1);
      else if (state_nxt == S_COMPLETE && state != S_COMPLETE)
        tmr <= CNT_W'(BUZZ_CYCLES - 1);
      else if (tmr != '0)
        tmr <= tmr - CNT_W'(1);
      if (state == S_READY && mode_press)
        prog <= next_prog(prog);
    end
  end

  always_comb begin
    state_nxt   = state;
    start       = 1'b0;
    door_lock   = 1'b0;
    time_pause  = 1'b0;
    led_running = 1'b0;
    led_paused  = 1'b0;
    led_fault   = 1'b0;
    buzzer      = 1'b0;
    case (state)
      S_READY: begin
        if (start_press && door_lvl && done) state_nxt = S_START_REQ;
      end
      S_START_REQ: begin
        // start drops combinationally the cycle done falls
        start       = done;
        door_lock   = 1'b1;
        led_running = 1'b1;
        if (error_signal)    state_nxt = S_FAULT;
        else if (!done)      state_nxt = S_RUNNING;
        else if (tmr == '0)  state_nxt = S_FAULT;
      end
      S_RUNNING: begin
        door_lock   = 1'b1;
        led_running = 1'b1;
        if (error_signal)     state_nxt = S_FAULT;
        else if (done)        state_nxt = S_COMPLETE;
        else if (pause_press) state_nxt = S_PAUSED;
      end
      S_PAUSED: begin
        door_lock   = 1'b1;
        time_pause  = 1'b1;
        led_running = 1'b1;
        led_paused  = 1'b1;
        if (error_signal)     state_nxt = S_FAULT;
        else if (done)        state_nxt = S_COMPLETE;
        else if (pause_press) state_nxt = S_RUNNING;
      end
      S_FAULT: begin
        led_fault = 1'b1;
        if (door_lvl) state_nxt = done ? S_READY : S_RUNNING;
      end
      S_COMPLETE: begin
        buzzer = 1'b1;
        if (tmr == '0) state_nxt = S_READY;
      end
      default: state_nxt = S_READY;
    endcase
  end

  assign program_sel = prog;
  assign double_wash = (prog == PROG_DOUBLE);
  assign dry_wash    = (prog == PROG_STEAM);
  assign door_closed = door_lvl;

endmodule

// File: tb/tb_washer_panel_ctrl.sv
// Directed self-checking bench for washer_panel_ctrl with short timing parameters.
module tb_washer_panel_ctrl;

  logic       clk, rst;
  logic       btn_start_raw, btn_pause_raw, btn_mode_raw, door_sensor_raw;
  logic       done, error_signal;
  logic       start, double_wash, dry_wash, time_pause, door_closed, door_lock;
  logic [1:0] program_sel;
  logic       led_running, led_paused, led_fault, buzzer;

  int n_tests = 0;
  int n_fail  = 0;
  int n_hi;

  washer_panel_ctrl #(
    .DEBOUNCE_CYCLES(4), .START_ACK_MAX(8), .BUZZ_CYCLES(16), .CNT_W(16)
  ) dut (
    .clk(clk), .rst(rst),
    .btn_start_raw(btn_start_raw), .btn_pause_raw(btn_pause_raw),
    .btn_mode_raw(btn_mode_raw), .door_sensor_raw(door_sensor_raw),
    .done(done), .error_signal(error_signal),
    .start(start), .double_wash(double_wash), .dry_wash(dry_wash),
    .time_pause(time_pause), .door_closed(door_closed), .door_lock(door_lock),
    .program_sel(program_sel), .led_running(led_running), .led_paused(led_paused),
    .led_fault(led_fault), .buzzer(buzzer)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // 0 = start, 1 = pause, 2 = mode; 8 cycles high covers the 2+4 cycle latency
  task automatic press(input int sel);
    case (sel)
      0: btn_start_raw = 1'b1;
      1: btn_pause_raw = 1'b1;
      default: btn_mode_raw = 1'b1;
    endcase
    step(8);
    btn_start_raw = 1'b0;
    btn_pause_raw = 1'b0;
    btn_mode_raw  = 1'b0;
    step(8);
  endtask

  initial begin
    rst = 1'b1;
    btn_start_raw = 1'b0; btn_pause_raw = 1'b0; btn_mode_raw = 1'b0;
    door_sensor_raw = 1'b0; done = 1'b1; error_signal = 1'b0;
    step(2);
    check_val("rst_prog", 32'(program_sel), 0);
    check_val("rst_start", 32'(start), 0);
    check_val("rst_lock", 32'(door_lock), 0);
    check_val("rst_door", 32'(door_closed), 0);
    check_val("rst_leds", 32'({led_running, led_paused, led_fault, buzzer}), 0);
    rst = 1'b0;
    step(2);

    // 3-cycle glitch is shorter than the 4-sample window
    btn_mode_raw = 1'b1; step(3); btn_mode_raw = 1'b0; step(10);
    check_val("glitch_prog", 32'(program_sel), 0);

    // held press: level at the 6th sampling edge, program updates on the next
    btn_mode_raw = 1'b1; step(6);
    check_val("db_early", 32'(program_sel), 0);
    step(1);
    check_val("db_prog1", 32'(program_sel), 1);
    check_val("db_double", 32'(double_wash), 1);
    step(3); btn_mode_raw = 1'b0; step(10);

    press(2);
    check_val("wrap_prog2", 32'(program_sel), 2);
    check_val("wrap_dry", 32'(dry_wash), 1);
    check_val("wrap_double", 32'(double_wash), 0);
    press(2);
    check_val("wrap_prog0", 32'(program_sel), 0);
    check_val("wrap_dry0", 32'(dry_wash), 0);

    press(1);
    check_val("ready_pause_ign", 32'(time_pause), 0);
    press(0);
    check_val("door_open_start", 32'(led_running), 0);

    door_sensor_raw = 1'b1; step(8);
    check_val("door_closed", 32'(door_closed), 1);

    // start handshake, done falls after 3 cycles of start
    btn_start_raw = 1'b1; step(6);
    check_val("hs_not_yet", 32'(led_running), 0);
    step(1);
    btn_start_raw = 1'b0;
    check_val("hs_start1", 32'(start), 1);
    check_val("hs_lock", 32'(door_lock), 1);
    check_val("hs_led", 32'(led_running), 1);
    step(1); check_val("hs_start2", 32'(start), 1);
    step(1); check_val("hs_start3", 32'(start), 1);
    step(1); done = 1'b0; #1;
    check_val("hs_drop", 32'(start), 0);
    step(1);
    check_val("run_led", 32'(led_running), 1);
    check_val("run_lock", 32'(door_lock), 1);
    check_val("run_tp", 32'(time_pause), 0);

    press(1);
    check_val("pause_tp", 32'(time_pause), 1);
    check_val("pause_led", 32'(led_paused), 1);
    check_val("pause_lock", 32'(door_lock), 1);
    press(1);
    check_val("resume_tp", 32'(time_pause), 0);
    check_val("resume_led", 32'(led_running), 1);

    done = 1'b1; step(1);
    check_val("cmp_lock", 32'(door_lock), 0);
    btn_start_raw = 1'b1;
    n_hi = 0;
    for (int i = 0; i < 20; i++) begin
      if (buzzer) n_hi++;
      step(1);
    end
    check_val("buzz_len", 32'(n_hi), 16);
    check_val("cmp_ready", 32'(led_running), 0);
    check_val("cmp_unlock", 32'(door_lock), 0);
    btn_start_raw = 1'b0; step(8);

    // ack timeout with done stuck high
    btn_start_raw = 1'b1; step(7);
    btn_start_raw = 1'b0;
    n_hi = 0;
    for (int i = 0; i < 8; i++) begin
      if (start) n_hi++;
      step(1);
    end
    check_val("ack_len", 32'(n_hi), 8);
    check_val("ack_start0", 32'(start), 0);
    check_val("ack_fault", 32'(led_fault), 1);
    check_val("ack_unlock", 32'(door_lock), 0);
    step(1);
    check_val("ack_exit_ready", 32'({led_fault, led_running}), 0);
    step(8);

    // fault from RUNNING with the door open, recover on close
    btn_start_raw = 1'b1; step(7);
    btn_start_raw = 1'b0; done = 1'b0; step(1);
    check_val("fr_running", 32'(led_running), 1);
    door_sensor_raw = 1'b0; step(8);
    check_val("fr_door_open", 32'(door_closed), 0);
    error_signal = 1'b1; step(1); error_signal = 1'b0;
    check_val("fr_fault", 32'(led_fault), 1);
    check_val("fr_unlock", 32'(door_lock), 0);
    step(1);
    door_sensor_raw = 1'b1; step(6);
    check_val("fr_still_fault", 32'(led_fault), 1);
    step(1);
    check_val("fr_clear", 32'(led_fault), 0);
    check_val("fr_back_run", 32'(led_running), 1);

    // async reset mid-run
    rst = 1'b1; #1;
    check_val("arst_run", 32'(led_running), 0);
    check_val("arst_door", 32'(door_closed), 0);
    check_val("arst_lock", 32'(door_lock), 0);
    step(1);
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
